// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit:
// opcode constants, FSM state encoding, instruction classes and the
// packed control-line bundle driven by control_unit.
package cpu_ctrl_pkg;

   localparam int unsigned OPC_W = 32'd5;
   localparam int unsigned ALU_W = 32'd5;

   localparam logic [ALU_W-1:0] ADD_OP = 5'b00011;

   // Opcodes (IR[31:27])
   localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
   localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
   localparam logic [OPC_W-1:0] OP_JAL  = 5'b10101;
   localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
   localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
   localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RESET = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_T6    = 4'd7,
      ST_T7    = 4'd8,
      ST_HALT  = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      CL_LOAD    = 4'd0,
      CL_LDI     = 4'd1,
      CL_STORE   = 4'd2,
      CL_ALU_R   = 4'd3,
      CL_ALU_U   = 4'd4,
      CL_ALU_I   = 4'd5,
      CL_BRANCH  = 4'd6,
      CL_JR      = 4'd7,
      CL_JAL     = 4'd8,
      CL_IN      = 4'd9,
      CL_OUT     = 4'd10,
      CL_NOP     = 4'd11,
      CL_HALT    = 4'd12,
      CL_ILLEGAL = 4'd13
   } iclass_t;

   // All datapath control lines in one bundle so they can be registered together
   typedef struct packed {
      logic             pc_out;
      logic             inc_pc;
      logic             zlo_out;
      logic             mdr_out;
      logic             c_out;
      logic             ba_out;
      logic             mar_in;
      logic             pc_in;
      logic             mdr_in;
      logic             ir_in;
      logic             y_in;
      logic             zlo_in;
      logic             r15_in;
      logic             gra;
      logic             grb;
      logic             grc;
      logic             r_in;
      logic             r_out;
      logic             rd;
      logic             wr;
      logic             ram_en;
      logic             con_in;
      logic             out_port_en;
      logic             port_in_out;
      logic [ALU_W-1:0] alu_ctl;
      logic             run;
   } ctl_t;

   // Classes whose execute phase finishes with the ZLOout -> Rin write-back in T5
   function automatic logic ends_at_t5(input iclass_t c);
      logic v;
      case (c)
         CL_LDI, CL_ALU_R, CL_ALU_U, CL_ALU_I: v = 1'b1;
         default:                             v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode -> instruction-class decoder for control_unit.
module instr_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] i_opcode,
   output iclass_t          o_class
);

   // Map each opcode onto the execute sequence family that runs it
   always_comb begin
      o_class = CL_ILLEGAL;
      case (i_opcode)
         OP_LD:                                 o_class = CL_LOAD;
         OP_LDI:                                o_class = CL_LDI;
         OP_ST:                                 o_class = CL_STORE;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       o_class = CL_ALU_R;
         OP_ADDI, OP_ANDI, OP_ORI:              o_class = CL_ALU_I;
         OP_NEG, OP_NOT:                        o_class = CL_ALU_U;
         OP_BR:                                 o_class = CL_BRANCH;
         OP_JR:                                 o_class = CL_JR;
         OP_JAL:                                o_class = CL_JAL;
         OP_IN:                                 o_class = CL_IN;
         OP_OUT:                                o_class = CL_OUT;
         OP_NOP:                                o_class = CL_NOP;
         OP_HALT:                               o_class = CL_HALT;
         default:                               o_class = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for the Mini-SRC datapath.
// Fetch T0-T2, decode in T3, execute up to T7, then back to T0 (or HALT
// when stop is high in the last state). All control lines are registered:
// the value shown in a state is computed at the edge that enters it.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (unsupported opcodes halt and
// raise the illegal output; otherwise they run as nop).
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic [31:0]      IR,
   input  logic             con_ff,
   input  logic             stop,
   output logic             PCout,
   output logic             IncPC,
   output logic             ZLOout,
   output logic             MDRout,
   output logic             Cout,
   output logic             BAout,
   output logic             MARin,
   output logic             PCin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             ZLOin,
   output logic             R15in,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             Rin,
   output logic             Rout,
   output logic             read,
   output logic             write,
   output logic             RAMenable,
   output logic             conin,
   output logic             OutPortenable,
   output logic             PortInout,
   output logic [ALU_W-1:0] aluControl,
`ifdef CU_ILLEGAL_TRAP_EN
   output logic             illegal,
`endif
   output logic             run
);

   state_t           r_state;
   ctl_t             r_ctl;
   state_t           w_next;
   state_t           w_done;
   ctl_t             w_ctl;
   iclass_t          w_class;
   logic [OPC_W-1:0] w_opcode;
   logic             w_unused_ir;
`ifdef CU_ILLEGAL_TRAP_EN
   logic             r_illegal;
   logic             w_trap;
`endif

   assign w_opcode    = IR[31:27];
   assign w_unused_ir = ^IR[26:0];

   instr_class_decode u_decode (
      .i_opcode (w_opcode),
      .o_class  (w_class)
   );

   // Successor of the final state of any sequence: next fetch, or HALT on a stop request
   assign w_done = stop ? ST_HALT : ST_T0;

   // Next-state selection: instruction length depends on the decoded class
   always_comb begin
      w_next = ST_RESET;
`ifdef CU_ILLEGAL_TRAP_EN
      w_trap = 1'b0;
`endif
      case (r_state)
         ST_RESET: w_next = ST_T0;
         ST_T0:    w_next = ST_T1;
         ST_T1:    w_next = ST_T2;
         ST_T2:    w_next = ST_T3;
         ST_T3: begin
            case (w_class)
               CL_LOAD, CL_LDI, CL_STORE, CL_ALU_R, CL_ALU_U,
               CL_ALU_I, CL_BRANCH, CL_JAL:  w_next = ST_T4;
               CL_HALT:                      w_next = ST_HALT;
               CL_ILLEGAL: begin
`ifdef CU_ILLEGAL_TRAP_EN
                  w_next = ST_HALT;
                  w_trap = 1'b1;
`else
                  w_next = w_done;
`endif
               end
               default:                      w_next = w_done;
            endcase
         end
         ST_T4: begin
            if (w_class == CL_JAL) begin
               w_next = w_done;
            end else begin
               w_next = ST_T5;
            end
         end
         ST_T5: begin
            if (ends_at_t5(w_class)) begin
               w_next = w_done;
            end else begin
               w_next = ST_T6;
            end
         end
         ST_T6: begin
            if (w_class == CL_BRANCH) begin
               w_next = w_done;
            end else begin
               w_next = ST_T7;
            end
         end
         ST_T7:    w_next = w_done;
         ST_HALT:  w_next = ST_HALT;
         default:  w_next = ST_RESET;
      endcase
   end

   // Control-line decode for the state about to be entered
   always_comb begin
      w_ctl = '0;
      case (w_next)
         ST_T0: begin
            w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1; w_ctl.inc_pc = 1'b1;
         end
         ST_T1: begin
            w_ctl.rd = 1'b1; w_ctl.ram_en = 1'b1; w_ctl.mdr_in = 1'b1;
         end
         ST_T2: begin
            w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1;
         end
         ST_T3: begin
            case (w_class)
               CL_LOAD, CL_LDI, CL_STORE: begin
                  w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1;
               end
               CL_ALU_R, CL_ALU_U, CL_ALU_I: begin
                  w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.y_in = 1'b1;
               end
               CL_BRANCH: begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.con_in = 1'b1;
               end
               CL_JR: begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.pc_in = 1'b1;
               end
               CL_JAL: begin
                  w_ctl.pc_out = 1'b1; w_ctl.r15_in = 1'b1;
               end
               CL_IN: begin
                  w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1; w_ctl.port_in_out = 1'b1;
               end
               CL_OUT: begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.out_port_en = 1'b1;
               end
               default: w_ctl.r_out = 1'b0;
            endcase
         end
         ST_T4: begin
            case (w_class)
               CL_LOAD, CL_LDI, CL_STORE: begin
                  w_ctl.c_out = 1'b1; w_ctl.alu_ctl = ADD_OP; w_ctl.zlo_in = 1'b1;
               end
               CL_ALU_R: begin
                  w_ctl.grc = 1'b1; w_ctl.r_out = 1'b1; w_ctl.alu_ctl = w_opcode; w_ctl.zlo_in = 1'b1;
               end
               CL_ALU_U: begin
                  w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.alu_ctl = w_opcode; w_ctl.zlo_in = 1'b1;
               end
               CL_ALU_I: begin
                  w_ctl.c_out = 1'b1; w_ctl.alu_ctl = w_opcode; w_ctl.zlo_in = 1'b1;
               end
               CL_BRANCH: begin
                  w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1;
               end
               CL_JAL: begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.pc_in = 1'b1;
               end
               default: w_ctl.r_out = 1'b0;
            endcase
         end
         ST_T5: begin
            case (w_class)
               CL_LOAD, CL_STORE: begin
                  w_ctl.zlo_out = 1'b1; w_ctl.mar_in = 1'b1;
               end
               CL_LDI, CL_ALU_R, CL_ALU_U, CL_ALU_I: begin
                  w_ctl.zlo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               CL_BRANCH: begin
                  w_ctl.c_out = 1'b1; w_ctl.alu_ctl = ADD_OP; w_ctl.zlo_in = 1'b1;
               end
               default: w_ctl.r_out = 1'b0;
            endcase
         end
         ST_T6: begin
            case (w_class)
               CL_LOAD: begin
                  w_ctl.rd = 1'b1; w_ctl.ram_en = 1'b1; w_ctl.mdr_in = 1'b1;
               end
               CL_STORE: begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.mdr_in = 1'b1;
               end
               CL_BRANCH: begin
                  // branch target is written back only when the condition holds
                  w_ctl.zlo_out = con_ff; w_ctl.pc_in = con_ff;
               end
               default: w_ctl.r_out = 1'b0;
            endcase
         end
         ST_T7: begin
            case (w_class)
               CL_LOAD: begin
                  w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               CL_STORE: begin
                  w_ctl.wr = 1'b1; w_ctl.ram_en = 1'b1;
               end
               default: w_ctl.r_out = 1'b0;
            endcase
         end
         default: w_ctl.run = 1'b0;
      endcase
      if ((w_next != ST_RESET) && (w_next != ST_HALT)) begin
         w_ctl.run = 1'b1;
      end else begin
         w_ctl.run = 1'b0;
      end
   end

   // State, control-line and trap registers; clear overrides everything
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state   <= ST_RESET;
         r_ctl     <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else begin
         r_state   <= w_next;
         r_ctl     <= w_ctl;
`ifdef CU_ILLEGAL_TRAP_EN
         if (w_trap) begin
            r_illegal <= 1'b1;
         end else begin
            r_illegal <= r_illegal;
         end
`endif
      end
   end

   assign PCout         = r_ctl.pc_out;
   assign IncPC         = r_ctl.inc_pc;
   assign ZLOout        = r_ctl.zlo_out;
   assign MDRout        = r_ctl.mdr_out;
   assign Cout          = r_ctl.c_out;
   assign BAout         = r_ctl.ba_out;
   assign MARin         = r_ctl.mar_in;
   assign PCin          = r_ctl.pc_in;
   assign MDRin         = r_ctl.mdr_in;
   assign IRin          = r_ctl.ir_in;
   assign Yin           = r_ctl.y_in;
   assign ZLOin         = r_ctl.zlo_in;
   assign R15in         = r_ctl.r15_in;
   assign Gra           = r_ctl.gra;
   assign Grb           = r_ctl.grb;
   assign Grc           = r_ctl.grc;
   assign Rin           = r_ctl.r_in;
   assign Rout          = r_ctl.r_out;
   assign read          = r_ctl.rd;
   assign write         = r_ctl.wr;
   assign RAMenable     = r_ctl.ram_en;
   assign conin         = r_ctl.con_in;
   assign OutPortenable = r_ctl.out_port_en;
   assign PortInout     = r_ctl.port_in_out;
   assign aluControl    = r_ctl.alu_ctl;
   assign run           = r_ctl.run;
`ifdef CU_ILLEGAL_TRAP_EN
   assign illegal       = r_illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table, hand-written
// corner sequences and randomized instructions against a per-opcode model.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clear, con_ff, stop;
   logic [31:0] IR;
   logic PCout, IncPC, ZLOout, MDRout, Cout, BAout, MARin, PCin, MDRin, IRin;
   logic Yin, ZLOin, R15in, Gra, Grb, Grc, Rin, Rout, read, write, RAMenable;
   logic conin, OutPortenable, PortInout, run;
   logic [4:0] aluControl;
`ifdef CU_ILLEGAL_TRAP_EN
   logic illegal;
`endif

   always #5 clk = ~clk;

   control_unit dut (
      .clock(clk), .clear(clear), .IR(IR), .con_ff(con_ff), .stop(stop),
      .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .MDRout(MDRout), .Cout(Cout),
      .BAout(BAout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .ZLOin(ZLOin), .R15in(R15in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .read(read), .write(write), .RAMenable(RAMenable),
      .conin(conin), .OutPortenable(OutPortenable), .PortInout(PortInout),
      .aluControl(aluControl),
`ifdef CU_ILLEGAL_TRAP_EN
      .illegal(illegal),
`endif
      .run(run)
   );

   // Observed strobes as one vector, bit per line
   logic [24:0] obs;
   assign obs = {run, PortInout, OutPortenable, conin, RAMenable, write, read, Rout, Rin,
                 Grc, Grb, Gra, R15in, ZLOin, Yin, IRin, MDRin, PCin, MARin, BAout,
                 Cout, MDRout, ZLOout, IncPC, PCout};

   localparam logic [24:0] PCOUT  = 25'd1 << 0,  INCPC  = 25'd1 << 1,  ZLOOUT = 25'd1 << 2;
   localparam logic [24:0] MDROUT = 25'd1 << 3,  COUT   = 25'd1 << 4,  BAOUT  = 25'd1 << 5;
   localparam logic [24:0] MARIN  = 25'd1 << 6,  PCIN   = 25'd1 << 7,  MDRIN  = 25'd1 << 8;
   localparam logic [24:0] IRIN   = 25'd1 << 9,  YIN    = 25'd1 << 10, ZLOIN  = 25'd1 << 11;
   localparam logic [24:0] R15IN  = 25'd1 << 12, GRA    = 25'd1 << 13, GRB    = 25'd1 << 14;
   localparam logic [24:0] GRC    = 25'd1 << 15, RIN    = 25'd1 << 16, ROUT   = 25'd1 << 17;
   localparam logic [24:0] READ   = 25'd1 << 18, WRITE  = 25'd1 << 19, RAMEN  = 25'd1 << 20;
   localparam logic [24:0] CONIN  = 25'd1 << 21, OUTPE  = 25'd1 << 22, PORTIO = 25'd1 << 23;
   localparam logic [24:0] RUN    = 25'd1 << 24;
   localparam logic [4:0]  ADD    = 5'b00011;

   typedef struct { logic [24:0] mask; logic [4:0] alu; } exp_t;
   exp_t exp_q[$];
   logic exp_halt, exp_ill;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
      end
   endtask

   function automatic void push(input logic [24:0] m, input logic [4:0] a);
      exp_q.push_back('{mask: m | RUN, alu: a});
   endfunction

   // Reference: whole per-cycle line list of one instruction, fetch included
   function automatic void build_expected(input logic [4:0] op, input logic con, input logic stp);
      exp_q.delete();
      exp_halt = stp;
      exp_ill  = 1'b0;
      push(PCOUT | MARIN | INCPC, 5'd0);
      push(READ | RAMEN | MDRIN, 5'd0);
      push(MDROUT | IRIN, 5'd0);
      if (op inside {5'd0, 5'd1, 5'd2}) begin
         push(GRB | BAOUT | YIN, 5'd0);
         push(COUT | ZLOIN, ADD);
         if (op == 5'd1) push(ZLOOUT | GRA | RIN, 5'd0);
         else begin
            push(ZLOOUT | MARIN, 5'd0);
            if (op == 5'd0) begin
               push(READ | RAMEN | MDRIN, 5'd0);
               push(MDROUT | GRA | RIN, 5'd0);
            end else begin
               push(GRA | ROUT | MDRIN, 5'd0);
               push(WRITE | RAMEN, 5'd0);
            end
         end
      end else if (op inside {[5'd3:5'd14], 5'd17, 5'd18}) begin
         push(GRB | ROUT | YIN, 5'd0);
         if (op inside {[5'd12:5'd14]})  push(COUT | ZLOIN, op);
         else if (op >= 5'd17)          push(GRB | ROUT | ZLOIN, op);
         else                           push(GRC | ROUT | ZLOIN, op);
         push(ZLOOUT | GRA | RIN, 5'd0);
      end else if (op == 5'd19) begin
         push(GRA | ROUT | CONIN, 5'd0);
         push(PCOUT | YIN, 5'd0);
         push(COUT | ZLOIN, ADD);
         push(con ? (ZLOOUT | PCIN) : 25'd0, 5'd0);
      end else if (op == 5'd20) push(GRA | ROUT | PCIN, 5'd0);
      else if (op == 5'd21) begin
         push(PCOUT | R15IN, 5'd0);
         push(GRA | ROUT | PCIN, 5'd0);
      end else if (op == 5'd22) push(GRA | RIN | PORTIO, 5'd0);
      else if (op == 5'd23) push(GRA | ROUT | OUTPE, 5'd0);
      else if (op == 5'd26) push(25'd0, 5'd0);
      else if (op == 5'd27) begin
         push(25'd0, 5'd0);
         exp_halt = 1'b1;
      end else begin
         push(25'd0, 5'd0);
`ifdef CU_ILLEGAL_TRAP_EN
         exp_halt = 1'b1;
         exp_ill  = 1'b1;
`endif
      end
   endfunction

   // Entry: at a negedge inside a T0 cycle. Exit: at the negedge of the following state.
   task automatic run_instr(input string nm, input logic [31:0] ir, input logic con,
                            input logic stp, output logic [4:0] alu4, output logic post_run);
      logic [4:0] op;
      op = ir[31:27];
      build_expected(op, con, stp);
      alu4 = 5'd0;
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k > 0) begin @(posedge clk); @(negedge clk); end
         check($sformatf("%s.T%0d", nm, k), {2'b00, obs, aluControl},
               {2'b00, exp_q[k].mask, exp_q[k].alu});
         if (k == 0) begin IR = ir; con_ff = con; stop = stp; end
         if (k == 4) alu4 = aluControl;
      end
      @(posedge clk); @(negedge clk);
      post_run = run;
      check($sformatf("%s.after", nm), {2'b00, obs, aluControl},
            exp_halt ? 32'd0 : {2'b00, PCOUT | MARIN | INCPC | RUN, 5'd0});
`ifdef CU_ILLEGAL_TRAP_EN
      check($sformatf("%s.illegal", nm), {31'd0, illegal}, {31'd0, exp_ill});
`endif
      stop = 1'b0;
   endtask

   // Two cycles of clear with all lines low, then release into T0
   task automatic do_reset();
      clear = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); @(negedge clk);
         check("reset.lines", {2'b00, obs, aluControl}, 32'd0);
      end
`ifdef CU_ILLEGAL_TRAP_EN
      check("reset.illegal", {31'd0, illegal}, 32'd0);
`endif
      clear = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   typedef struct {
      string       nm;
      logic [31:0] ir;
      logic        con;
      logic        stp;
      logic [4:0]  alu4;
      logic        halts;
   } vec_t;
   vec_t vt[12];

   initial begin
      logic [4:0] a4;
      logic       pr;
      logic [31:0] rnd;
      clear = 1'b1; IR = 32'd0; con_ff = 1'b0; stop = 1'b0;

      vt[0]  = '{"ldi",    32'h09000005, 1'b0, 1'b0, 5'b00011, 1'b0};
      vt[1]  = '{"add",    32'h19890000, 1'b0, 1'b0, 5'b00011, 1'b0};
      vt[2]  = '{"br_nt",  32'h98000000, 1'b0, 1'b0, 5'b00000, 1'b0};
      vt[3]  = '{"br_t",   32'h98000000, 1'b1, 1'b0, 5'b00000, 1'b0};
      vt[4]  = '{"sub",    32'h20880000, 1'b0, 1'b0, 5'b00100, 1'b0};
      vt[5]  = '{"neg",    32'h88800000, 1'b0, 1'b0, 5'b10001, 1'b0};
      vt[6]  = '{"andi",   32'h6880000F, 1'b0, 1'b0, 5'b01101, 1'b0};
      vt[7]  = '{"ld",     32'h01000010, 1'b0, 1'b0, 5'b00011, 1'b0};
      vt[8]  = '{"st",     32'h11000010, 1'b0, 1'b0, 5'b00011, 1'b0};
      vt[9]  = '{"jal",    32'hA8800000, 1'b0, 1'b0, 5'b00000, 1'b0};
      vt[10] = '{"shl",    32'h59890000, 1'b1, 1'b0, 5'b01011, 1'b0};
      vt[11] = '{"ldi_stp",32'h09000005, 1'b0, 1'b1, 5'b00011, 1'b1};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         run_instr(vt[i].nm, vt[i].ir, vt[i].con, vt[i].stp, a4, pr);
         check({vt[i].nm, ".alu_t4"}, {27'd0, a4}, {27'd0, vt[i].alu4});
         check({vt[i].nm, ".run_after"}, {31'd0, pr}, {31'd0, ~vt[i].halts});
      end
      // stopped after ldi: must stay halted
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         check("stop_halt.hold", {2'b00, obs, aluControl}, 32'd0);
      end

      // clear in st T6: write must never appear, fetch restarts
      do_reset();
      IR = 32'h11000010;
      for (int c = 0; c < 6; c++) begin @(posedge clk); @(negedge clk); end
      check("st_clr.T6", {2'b00, obs, aluControl}, {2'b00, GRA | ROUT | MDRIN | RUN, 5'd0});
      clear = 1'b1;
      @(posedge clk); @(negedge clk);
      check("st_clr.zero", {2'b00, obs, aluControl}, 32'd0);
      check("st_clr.write", {31'd0, write}, 32'd0);
      clear = 1'b0;
      @(posedge clk); @(negedge clk);
      check("st_clr.T0", {2'b00, obs, aluControl}, {2'b00, PCOUT | MARIN | INCPC | RUN, 5'd0});

      // halt opcode: run=0 from the cycle after T3, held for 10 cycles
      IR = 32'hD8000000;
      for (int c = 0; c < 3; c++) begin @(posedge clk); @(negedge clk); end
      check("halt.T3", {2'b00, obs, aluControl}, {2'b00, RUN, 5'd0});
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); @(negedge clk);
         check("halt.hold", {2'b00, obs, aluControl}, 32'd0);
      end
      do_reset();

`ifdef CU_ILLEGAL_TRAP_EN
      run_instr("trap", 32'hF8000000, 1'b0, 1'b0, a4, pr);
      @(posedge clk); @(negedge clk);
      check("trap.hold", {30'd0, illegal, run}, 32'd2);
      do_reset();
`endif

      // randomized instruction stream
      for (int i = 0; i < 80; i++) begin
         rnd = $urandom();
         rnd[31:27] = 5'($urandom_range(0, 31));
         run_instr($sformatf("rnd%0d", i), rnd, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), a4, pr);
         if (exp_halt) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
